// File: rtl/fir_sequencer.sv
// fir_sequencer: loads NUM_TAPS coefficients into the fir, then feeds
// samples one at a time and hands each result downstream.
module fir_sequencer #(
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 16,
  parameter int NUM_TAPS = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] fir_data_in,
  output logic              fir_coef_enable,
  output logic              fir_sample_enable,
  input  logic [OUT_W-1:0]  fir_data_out,
  input  logic              fir_out_enable,
  input  logic              fir_error,
  output logic              m_valid,
  output logic [OUT_W-1:0]  m_data,
  input  logic              m_ready,
  output logic              loaded,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int IW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int CW = IW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] LAST_TAP = CW'(NUM_TAPS - 1);
  localparam logic [CW-1:0] TAPS     = CW'(NUM_TAPS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] E_FIR   = 2'd1;
  localparam logic [1:0] E_TMO   = 2'd2;
  localparam logic [1:0] E_STRAY = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_BURST,
    S_READY,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] coef_q [NUM_TAPS];
  logic [DATA_W-1:0] coef_d [NUM_TAPS];

  logic              cfg_ready_d;
  logic              s_ready_d;
  logic [DATA_W-1:0] data_in_d;
  logic              coef_en_d;
  logic              samp_en_d;
  logic              m_valid_d;
  logic [OUT_W-1:0]  m_data_d;
  logic              loaded_d;
  logic              err_d;
  logic [1:0]        code_d;

  logic              trap;
  logic [1:0]        trap_code;

  always_comb begin
    trap      = 1'b0;
    trap_code = 2'd0;
    // fir_error outranks a stray out_enable, which outranks a timeout
    if (fir_error &&
        state_q != S_IDLE &&
        state_q != S_ERR) begin
      trap      = 1'b1;
      trap_code = E_FIR;
    end else if (fir_out_enable &&
                 (state_q == S_READY ||
                  state_q == S_HOLD)) begin
      trap      = 1'b1;
      trap_code = E_STRAY;
    end else if (state_q == S_WAIT &&
                 !fir_out_enable &&
                 timer_q == TMO_LAST) begin
      trap      = 1'b1;
      trap_code = E_TMO;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    coef_d      = coef_q;
    cfg_ready_d = cfg_ready;
    s_ready_d   = s_ready;
    data_in_d   = fir_data_in;
    coef_en_d   = 1'b0;
    samp_en_d   = 1'b0;
    m_valid_d   = m_valid;
    m_data_d    = m_data;
    loaded_d    = loaded;
    err_d       = err;
    code_d      = err_code;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d     = S_COLLECT;
          cfg_ready_d = 1'b1;
          cnt_d       = '0;
        end
      end
      S_COLLECT: begin
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_valid) begin
          coef_d[cnt_q[IW-1:0]] = cfg_data;
          if (cnt_q == LAST_TAP) begin
            state_d     = S_BURST;
            cfg_ready_d = 1'b0;
            coef_en_d   = 1'b1;
            // word 0 may be the one arriving now
            data_in_d   = (cnt_q == '0) ? cfg_data
                                        : coef_q[0];
            cnt_d       = CW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_BURST: begin
        if (cnt_q == TAPS) begin
          state_d   = S_READY;
          loaded_d  = 1'b1;
          s_ready_d = 1'b1;
          cnt_d     = '0;
        end else begin
          coef_en_d = 1'b1;
          data_in_d = coef_q[cnt_q[IW-1:0]];
          cnt_d     = cnt_q + CW'(1);
        end
      end
      S_READY: begin
        if (s_valid && s_ready) begin
          state_d   = S_WAIT;
          s_ready_d = 1'b0;
          samp_en_d = 1'b1;
          data_in_d = s_data;
          timer_d   = '0;
        end else if (cfg_start) begin
          state_d     = S_COLLECT;
          loaded_d    = 1'b0;
          s_ready_d   = 1'b0;
          cfg_ready_d = 1'b1;
          cnt_d       = '0;
        end
      end
      S_WAIT: begin
        if (fir_out_enable) begin
          state_d   = S_HOLD;
          m_valid_d = 1'b1;
          m_data_d  = fir_data_out;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HOLD: begin
        if (m_ready) begin
          state_d   = S_READY;
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
        end
      end
      S_ERR: begin
        if (cfg_start) begin
          state_d     = S_COLLECT;
          err_d       = 1'b0;
          code_d      = 2'd0;
          cfg_ready_d = 1'b1;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (trap) begin
      state_d     = S_ERR;
      err_d       = 1'b1;
      code_d      = trap_code;
      loaded_d    = 1'b0;
      cfg_ready_d = 1'b0;
      s_ready_d   = 1'b0;
      m_valid_d   = 1'b0;
      coef_en_d   = 1'b0;
      samp_en_d   = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      timer_q           <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef_q[i] <= '0;
      end
      cfg_ready         <= 1'b0;
      s_ready           <= 1'b0;
      fir_data_in       <= '0;
      fir_coef_enable   <= 1'b0;
      fir_sample_enable <= 1'b0;
      m_valid           <= 1'b0;
      m_data            <= '0;
      loaded            <= 1'b0;
      err               <= 1'b0;
      err_code          <= 2'd0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      timer_q           <= timer_d;
      coef_q            <= coef_d;
      cfg_ready         <= cfg_ready_d;
      s_ready           <= s_ready_d;
      fir_data_in       <= data_in_d;
      fir_coef_enable   <= coef_en_d;
      fir_sample_enable <= samp_en_d;
      m_valid           <= m_valid_d;
      m_data            <= m_data_d;
      loaded            <= loaded_d;
      err               <= err_d;
      err_code          <= code_d;
    end
  end

endmodule
